// File: rtl/led_blink_bank.sv
`timescale 1ns/1ps
// Multi-channel LED blinker / one-shot pulse generator with per-channel programmable half-period.
// Optional one-shot mode is compiled in when LED_BLINK_ONESHOT_EN is defined; otherwise mode 11 acts as off.
module led_blink_bank #(
  parameter int CH = 4,
  parameter int CNT_W = 26,
  parameter int DEFAULT_HALF = 25000000,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [CW-1:0]    CFG_CH,
  input  logic [CNT_W-1:0] CFG_HALF,
  input  logic [1:0]       CFG_MODE,
  input  logic [CH-1:0]    START,
  output logic [CH-1:0]    LED,
  output logic [CH-1:0]    BUSY,
  output logic [CH-1:0]    WRAP
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CW:0]      CH_LIM   = (CW + 1)'(CH);

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_reload;

  assign cfg_valid  = CFG_WE && ({1'b0, CFG_CH} < CH_LIM);
  assign cfg_reload = (CFG_HALF == '0) ? '0 : CFG_HALF - ONE;

`ifndef LED_BLINK_ONESHOT_EN
  logic start_unused;
  assign start_unused = |START;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      localparam logic [CW-1:0] IDX = CW'(gi);

      mode_t            mode_reg, mode_next;
      logic [CNT_W-1:0] half_reg, half_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             led_reg, led_next;
      logic             busy_reg, busy_next;
      logic             wrap_reg, wrap_next;
      logic             hit;
      logic [CNT_W-1:0] reload;

      assign hit    = cfg_valid && (CFG_CH == IDX);
      // Half-period of zero behaves as one, so the reload value floors at zero.
      assign reload = (half_reg == '0) ? '0 : half_reg - ONE;

      always_comb begin
        mode_next = mode_reg;
        half_next = half_reg;
        cnt_next  = cnt_reg;
        led_next  = led_reg;
        busy_next = busy_reg;
        wrap_next = 1'b0;
        if (hit) begin
          mode_next = mode_t'(CFG_MODE);
          half_next = CFG_HALF;
          cnt_next  = cfg_reload;
          led_next  = 1'b0;
          busy_next = 1'b0;
        end else begin
          unique case (mode_reg)
            MODE_ON: begin
              led_next  = 1'b1;
              busy_next = 1'b0;
              cnt_next  = reload;
            end
            MODE_BLINK: begin
              busy_next = 1'b0;
              if (cnt_reg == '0) begin
                led_next  = ~led_reg;
                cnt_next  = reload;
                wrap_next = 1'b1;
              end else begin
                cnt_next = cnt_reg - ONE;
              end
            end
`ifdef LED_BLINK_ONESHOT_EN
            MODE_ONESHOT: begin
              // Non-retriggerable: START is only looked at while idle.
              if (busy_reg) begin
                if (cnt_reg == '0) begin
                  led_next  = 1'b0;
                  busy_next = 1'b0;
                  wrap_next = 1'b1;
                  cnt_next  = reload;
                end else begin
                  cnt_next = cnt_reg - ONE;
                end
              end else begin
                led_next  = START[gi];
                busy_next = START[gi];
                cnt_next  = reload;
              end
            end
`endif
            default: begin
              led_next  = 1'b0;
              busy_next = 1'b0;
              cnt_next  = reload;
            end
          endcase
        end
      end

      always_ff @(posedge CLK50) begin
        if (RST) begin
          mode_reg <= MODE_BLINK;
          half_reg <= DEF_HALF;
          cnt_reg  <= DEF_HALF - ONE;
          led_reg  <= 1'b0;
          busy_reg <= 1'b0;
          wrap_reg <= 1'b0;
        end else begin
          mode_reg <= mode_next;
          half_reg <= half_next;
          cnt_reg  <= cnt_next;
          led_reg  <= led_next;
          busy_reg <= busy_next;
          wrap_reg <= wrap_next;
        end
      end

      assign LED[gi]  = led_reg;
      assign BUSY[gi] = busy_reg;
      assign WRAP[gi] = wrap_reg;
    end
  endgenerate

endmodule
